// File: rtl/crc_scheduler.sv
// Two-requester round-robin scheduler that runs a 66-bit serial CRC-16 (poly 0x8005)
// job per grant: requester 0 generates a CRC, requester 1 checks one against chk1.
module crc_scheduler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic [65:0] data0,
  input  logic        req1,
  input  logic [65:0] data1,
  input  logic [15:0] chk1,
  output logic [1:0]  gnt,
  output logic        busy,
  output logic        done0,
  output logic        done1,
  output logic [15:0] crc_out,
  output logic        crc_ok
);

  localparam int unsigned DATA_W = 66;
  localparam int unsigned CRC_W  = 16;
  localparam int unsigned CNT_W  = 7;
  localparam logic [CRC_W-1:0] POLY     = CRC_W'(16'h8005);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            r_state,   w_state;
  logic [DATA_W-1:0] r_sr,      w_sr;
  logic [CRC_W-1:0]  r_crc,     w_crc;
  logic [CRC_W-1:0]  r_chk,     w_chk;
  logic [CNT_W-1:0]  r_cnt,     w_cnt;
  logic [1:0]        r_gnt,     w_gnt;
  logic              r_busy,    w_busy;
  logic              r_done0,   w_done0;
  logic              r_done1,   w_done1;
  logic [CRC_W-1:0]  r_crc_out, w_crc_out;
  logic              r_crc_ok,  w_crc_ok;
  logic              r_prefer1, w_prefer1;

  logic              w_fb;
  logic [CRC_W-1:0]  w_crc_step;
  logic              w_win1;

  // One serial CRC step on the shift-register MSB
  always_comb begin
    w_fb       = r_crc[CRC_W-1] ^ r_sr[DATA_W-1];
    w_crc_step = {r_crc[CRC_W-2:0], 1'b0} ^ (w_fb ? POLY : '0);
    w_win1     = req1 & (~req0 | r_prefer1);
  end

  // Next-state and next-output logic
  always_comb begin
    w_state   = r_state;
    w_sr      = r_sr;
    w_crc     = r_crc;
    w_chk     = r_chk;
    w_cnt     = r_cnt;
    w_gnt     = r_gnt;
    w_busy    = r_busy;
    w_done0   = r_done0;
    w_done1   = r_done1;
    w_crc_out = r_crc_out;
    w_crc_ok  = r_crc_ok;
    w_prefer1 = r_prefer1;

    case (r_state)
      S_IDLE: begin
        if (req0 || req1) begin
          w_gnt  = w_win1 ? 2'b10 : 2'b01;
          w_sr   = w_win1 ? data1 : data0;
          if (w_win1) begin
            w_chk = chk1;
          end
          w_crc   = '0;
          w_cnt   = '0;
          w_busy  = 1'b1;
          w_state = S_SHIFT;
        end
      end
      S_SHIFT: begin
        w_sr  = {r_sr[DATA_W-2:0], 1'b0};
        w_crc = w_crc_step;
        w_cnt = r_cnt + CNT_W'(1);
        if (r_cnt == LAST_BIT) begin
          w_crc_out = w_crc_step;
          w_crc_ok  = r_gnt[1] && (w_crc_step == r_chk);
          w_done0   = r_gnt[0];
          w_done1   = r_gnt[1];
          w_state   = S_DONE;
        end
      end
      S_DONE: begin
        w_done0   = 1'b0;
        w_done1   = 1'b0;
        w_gnt     = 2'b00;
        w_busy    = 1'b0;
        // Served requester 0 means requester 1 wins the next tie
        w_prefer1 = r_gnt[0];
        w_state   = S_IDLE;
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_sr      <= '0;
      r_crc     <= '0;
      r_chk     <= '0;
      r_cnt     <= '0;
      r_gnt     <= '0;
      r_busy    <= 1'b0;
      r_done0   <= 1'b0;
      r_done1   <= 1'b0;
      r_crc_out <= '0;
      r_crc_ok  <= 1'b0;
      r_prefer1 <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_sr      <= w_sr;
      r_crc     <= w_crc;
      r_chk     <= w_chk;
      r_cnt     <= w_cnt;
      r_gnt     <= w_gnt;
      r_busy    <= w_busy;
      r_done0   <= w_done0;
      r_done1   <= w_done1;
      r_crc_out <= w_crc_out;
      r_crc_ok  <= w_crc_ok;
      r_prefer1 <= w_prefer1;
    end
  end

  assign gnt     = r_gnt;
  assign busy    = r_busy;
  assign done0   = r_done0;
  assign done1   = r_done1;
  assign crc_out = r_crc_out;
  assign crc_ok  = r_crc_ok;

endmodule

// File: tb/tb_crc_scheduler.sv
// Bench for crc_scheduler: job-timeline reference model compared every cycle,
// directed literal jobs, arbitration/back-to-back, reset behaviour, random traffic.
module tb_crc_scheduler;

  logic        clk;
  logic        rst_n;
  logic        req0;
  logic [65:0] data0;
  logic        req1;
  logic [65:0] data1;
  logic [15:0] chk1;
  logic [1:0]  gnt;
  logic        busy;
  logic        done0;
  logic        done1;
  logic [15:0] crc_out;
  logic        crc_ok;

  int checks = 0;
  int errors = 0;

  crc_scheduler dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req0    (req0),
    .data0   (data0),
    .req1    (req1),
    .data1   (data1),
    .chk1    (chk1),
    .gnt     (gnt),
    .busy    (busy),
    .done0   (done0),
    .done1   (done1),
    .crc_out (crc_out),
    .crc_ok  (crc_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference CRC: remainder of M(x)*x^16 divided by x^16+x^15+x^2+1
  function automatic logic [15:0] crc_ref(input logic [65:0] d);
    logic [81:0] v;
    v = {d, 16'h0000};
    for (int i = 81; i >= 16; i--) begin
      if (v[i]) v[i -: 17] = v[i -: 17] ^ 17'h18005;
    end
    return v[15:0];
  endfunction

  function automatic logic [65:0] rand66();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[65:0];
  endfunction

  // Job-timeline model: age 0 at the grant edge, done at age 66, idle again at age 67
  int          m_age = -1;
  bit          m_who;
  bit          m_pref1;
  logic [15:0] m_crc;
  logic [15:0] m_chk;
  logic [15:0] m_crc_out;
  bit          m_ok;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_age     = -1;
      m_pref1   = 1'b0;
      m_crc_out = 16'h0000;
      m_ok      = 1'b0;
    end else if (m_age < 0) begin
      if (req0 || req1) begin
        m_who = req1 && (!req0 || m_pref1);
        m_crc = crc_ref(m_who ? data1 : data0);
        m_chk = chk1;
        m_age = 0;
      end
    end else begin
      m_age++;
      if (m_age == 66) begin
        m_crc_out = m_crc;
        m_ok      = m_who && (m_crc == m_chk);
      end else if (m_age == 67) begin
        m_pref1 = !m_who;
        m_age   = -1;
      end
    end
    #1;
    chk("m_gnt",     32'(gnt),     (m_age >= 0) ? (m_who ? 32'd2 : 32'd1) : 32'd0);
    chk("m_busy",    32'(busy),    32'(m_age >= 0));
    chk("m_done0",   32'(done0),   32'(m_age == 66 && !m_who));
    chk("m_done1",   32'(done1),   32'(m_age == 66 && m_who));
    chk("m_crc_out", 32'(crc_out), 32'(m_crc_out));
    if (m_age == 66 && m_who) chk("m_crc_ok", 32'(crc_ok), 32'(m_ok));
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One job with literal expectations; request dropped and inputs scrambled after grant
  task automatic run_job(input bit sel, input logic [65:0] d, input logic [15:0] c,
                         input logic [15:0] exp_crc, input bit exp_ok, input string name);
    @(negedge clk);
    if (sel) begin
      req1 = 1'b1; data1 = d; chk1 = c;
    end else begin
      req0 = 1'b1; data0 = d;
    end
    @(posedge clk); #1;
    chk({name, "_gnt"}, 32'(gnt), sel ? 32'd2 : 32'd1);
    @(negedge clk);
    req0 = 1'b0; req1 = 1'b0;
    data0 = rand66(); data1 = rand66(); chk1 = 16'($urandom());
    for (int i = 1; i <= 66; i++) begin
      @(posedge clk); #1;
      if (i == 65) chk({name, "_early_done"}, 32'(done0 | done1), 32'd0);
    end
    chk({name, "_done0"}, 32'(done0), 32'(!sel));
    chk({name, "_done1"}, 32'(done1), 32'(sel));
    chk({name, "_crc"},   32'(crc_out), 32'(exp_crc));
    chk({name, "_ok"},    32'(crc_ok), 32'(exp_ok));
    @(posedge clk); #1;
    chk({name, "_end_gnt"},  32'(gnt), 32'd0);
    chk({name, "_end_done"}, 32'(done0 | done1), 32'd0);
  endtask

  initial begin
    int edges;
    int last_done;
    int n_done;
    bit found;
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
    data0 = '0; data1 = '0; chk1 = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    chk("ref_crc_2", 32'(crc_ref(66'h2)), 32'h800F);
    chk("ref_crc_1", 32'(crc_ref(66'h1)), 32'h8005);

    run_job(1'b0, 66'h0, 16'h0000, 16'h0000, 1'b0, "job_zero");
    run_job(1'b0, 66'h2, 16'h0000, 16'h800F, 1'b0, "job_two");
    run_job(1'b1, 66'h1, 16'h8005, 16'h8005, 1'b1, "cmp_good");
    run_job(1'b1, 66'h1, 16'h8004, 16'h8005, 1'b0, "cmp_bad");

    // Both requesters held after reset: alternate grants, 68-edge spacing
    do_reset();
    @(negedge clk);
    req0 = 1'b1; req1 = 1'b1;
    data0 = rand66(); data1 = rand66(); chk1 = 16'($urandom());
    edges = 0; last_done = 0; n_done = 0;
    @(posedge clk); #1;
    edges++;
    chk("b2b_first_gnt", 32'(gnt), 32'd1);
    while (n_done < 4 && edges < 400) begin
      @(posedge clk); #1;
      edges++;
      if (done0 || done1) begin
        chk("b2b_order", 32'(done1), 32'(n_done % 2));
        chk("b2b_gnt", 32'(gnt), (n_done % 2) ? 32'd2 : 32'd1);
        if (n_done > 0) chk("b2b_period", 32'(edges - last_done), 32'd68);
        last_done = edges;
        n_done++;
      end
    end
    chk("b2b_count", 32'(n_done), 32'd4);
    @(negedge clk);
    req0 = 1'b0; req1 = 1'b0;
    repeat (70) @(posedge clk);

    // Reset at E30 of a job, with random inputs applied during reset
    @(negedge clk);
    req0 = 1'b1; data0 = rand66();
    @(posedge clk);
    @(negedge clk);
    req0 = 1'b0;
    repeat (30) @(posedge clk);
    #2;
    rst_n = 1'b0;
    req0 = 1'($urandom()); req1 = 1'($urandom());
    data0 = rand66(); data1 = rand66(); chk1 = 16'($urandom());
    #1;
    chk("rst_async_gnt",  32'(gnt),     32'd0);
    chk("rst_async_busy", 32'(busy),    32'd0);
    chk("rst_async_done", 32'(done0 | done1), 32'd0);
    chk("rst_async_crc",  32'(crc_out), 32'd0);
    chk("rst_async_ok",   32'(crc_ok),  32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; req0 = 1'b0; req1 = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (done0 || done1) found = 1'b1;
    end
    chk("rst_no_done", 32'(found), 32'd0);
    chk("rst_idle_gnt", 32'(gnt), 32'd0);
    chk("rst_idle_busy", 32'(busy), 32'd0);
    chk("rst_crc_zero", 32'(crc_out), 32'd0);

    // Random traffic checked by the model every cycle
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 15) == 0) req0 = ~req0;
      if ($urandom_range(0, 15) == 0) req1 = ~req1;
      data0 = rand66();
      data1 = rand66();
      chk1  = ($urandom_range(0, 2) == 0) ? crc_ref(data1) : 16'($urandom());
      if ($urandom_range(0, 999) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
    end
    @(negedge clk);
    rst_n = 1'b1; req0 = 1'b0; req1 = 1'b0;
    repeat (80) @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
